data_ram_arbiter: RTL and testbench

//  Shares the single data_ram port between two bus masters: M0 (CPU data port) and M1 (DMA/debug loader).

---
 rtl/data_ram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
// Shares the single data_ram port between two bus masters:
//   M0 - CPU data port, M1 - DMA / debug loader.
// Round-robin between the two masters, with an optional bounded burst lock
// for M1. The grant is registered (IDLE/G0/G1). The RAM-side mux is
// combinational from the grant state, so a master is acked in the cycle
// after its request is first seen. The RAM has one access per cycle.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   mX_req_i                       access request; qualifiers held until ack
//   mX_write_en_i                  1 = write, 0 = read
//   mX_write_sel_i[3:0]            byte-lane enables
//   mX_addr_i, mX_write_data_i     address / write data
//   mX_ack_o                       access performed this cycle
//   mX_read_data_o                 read data, valid with ack, else 0
//   m1_lock_i                      M1 asks to hold the grant for a burst
//   ram_en_o, ram_write_en_o,
//   ram_write_sel_o, ram_addr_o,
//   ram_write_data_o               to data_ram
//   ram_read_data_i                from data_ram, combinational read
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module data_ram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_write_en_i,
    input  logic [3:0]        m0_write_sel_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_write_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_read_data_o,
    input  logic              m1_req_i,
    input  logic              m1_write_en_i,
    input  logic [3:0]        m1_write_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_write_data_i,
    input  logic              m1_lock_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_read_data_o,
    output logic              ram_en_o,
    output logic              ram_write_en_o,
    output logic [3:0]        ram_write_sel_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_write_data_o,
    input  logic [DATA_W-1:0] ram_read_data_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    localparam int                HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              m0_ack_s, m1_ack_s;
    logic              lock_stay_s;

    // RAM-side mux and per-master acks, driven only by the granted master.
    always_comb begin
        ram_en_o         = 1'b0;
        ram_write_en_o   = 1'b0;
        ram_write_sel_o  = 4'b0000;
        ram_addr_o       = {ADDR_W{1'b0}};
        ram_write_data_o = {DATA_W{1'b0}};
        m0_ack_s         = 1'b0;
        m1_ack_s         = 1'b0;
        m0_read_data_o   = {DATA_W{1'b0}};
        m1_read_data_o   = {DATA_W{1'b0}};
        case (state_q)
            ST_G0: begin
                // A granted master that has dropped req gets no access at all.
                ram_en_o         = m0_req_i;
                ram_write_en_o   = m0_write_en_i & m0_req_i;
                ram_write_sel_o  = m0_write_sel_i;
                ram_addr_o       = m0_addr_i;
                ram_write_data_o = m0_write_data_i;
                m0_ack_s         = m0_req_i;
                m0_read_data_o   = m0_req_i ? ram_read_data_i : {DATA_W{1'b0}};
            end
            ST_G1: begin
                ram_en_o         = m1_req_i;
                ram_write_en_o   = m1_write_en_i & m1_req_i;
                ram_write_sel_o  = m1_write_sel_i;
                ram_addr_o       = m1_addr_i;
                ram_write_data_o = m1_write_data_i;
                m1_ack_s         = m1_req_i;
                m1_read_data_o   = m1_req_i ? ram_read_data_i : {DATA_W{1'b0}};
            end
            default: begin
                ram_en_o = 1'b0;
            end
        endcase
    end

    assign m0_ack_o = m0_ack_s;
    assign m1_ack_o = m1_ack_s;

    // Next grant, last-winner and M1 burst counter.
    always_comb begin
        // The beat completing this cycle already counts as the last winner,
        // so a tie resolved now alternates immediately.
        if (m0_ack_s) begin
            last_d = LAST_M0;
        end else if (m1_ack_s) begin
            last_d = LAST_M1;
        end else begin
            last_d = last_q;
        end

        lock_stay_s = (state_q == ST_G1) && m1_ack_s && m1_lock_i && m1_req_i &&
                      (hold_q < HOLD_LIM);

        if (lock_stay_s) begin
            state_d = ST_G1;
        end else if (m0_req_i && m1_req_i) begin
            state_d = (last_d == LAST_M0) ? ST_G1 : ST_G0;
        end else if (m0_req_i) begin
            state_d = ST_G0;
        end else if (m1_req_i) begin
            state_d = ST_G1;
        end else begin
            state_d = ST_IDLE;
        end

        // Saturating at HOLD_LIM keeps M0 latency bounded even if M1 keeps locking.
        if (state_d == ST_IDLE) begin
            hold_d = {HOLD_W{1'b0}};
        end else if (m0_ack_s) begin
            hold_d = {HOLD_W{1'b0}};
        end else if (m1_ack_s && m1_lock_i) begin
            hold_d = (hold_q < HOLD_LIM) ? hold_q + {{(HOLD_W-1){1'b0}}, 1'b1} : hold_q;
        end else if (m1_ack_s) begin
            hold_d = {HOLD_W{1'b0}};
        end else begin
            hold_d = hold_q;
        end
    end

    // Arbiter state registers; reset makes M0 win the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_M1;
            hold_q  <= {HOLD_W{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// -----------------------------------------------------------------------------
// data_ram_arbiter_chk
// Property checker: at most one master is acked in any cycle.
// Ports: clk_i, rst_ni, m0_ack_i, m1_ack_i (observed acks).
// -----------------------------------------------------------------------------
module data_ram_arbiter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic m0_ack_i,
    input logic m1_ack_i
);

    a_one_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                !(m0_ack_i && m1_ack_i));

endmodule

// File: tb/tb_data_ram_arbiter.sv
`timescale 1ns/1ps
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_lock;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM model: word array, combinational read, byte-lane write on the edge.
    logic [31:0] mem [256];
    logic        load_en;
    logic [7:0]  load_idx;
    logic [31:0] load_val;
    logic        unused_addr_bits;

    assign ram_rdata        = mem[ram_addr[9:2]];
    assign unused_addr_bits = ^{ram_addr[31:10], ram_addr[1:0]};

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_val;
        end else if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_write_en_i(m0_we), .m0_write_sel_i(m0_sel),
        .m0_addr_i(m0_addr), .m0_write_data_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_read_data_o(m0_rdata),
        .m1_req_i(m1_req), .m1_write_en_i(m1_we), .m1_write_sel_i(m1_sel),
        .m1_addr_i(m1_addr), .m1_write_data_i(m1_wdata), .m1_lock_i(m1_lock),
        .m1_ack_o(m1_ack), .m1_read_data_o(m1_rdata),
        .ram_en_o(ram_en), .ram_write_en_o(ram_we), .ram_write_sel_o(ram_sel),
        .ram_addr_o(ram_addr), .ram_write_data_o(ram_wdata),
        .ram_read_data_i(ram_rdata)
    );

    data_ram_arbiter_chk u_chk (
        .clk_i(clk), .rst_ni(rst_n), .m0_ack_i(m0_ack), .m1_ack_i(m1_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_sel = 4'b0000; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_sel = 4'b0000; m1_addr = 32'd0; m1_wdata = 32'd0;
        m1_lock = 1'b0;
    endtask

    // Ends 1 ns after a rising edge with reset released; inputs set next form cycle 1.
    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_acks(input string tag, input logic e0, input logic e1);
        check_eq({tag, "_m0_ack"}, {31'd0, m0_ack}, {31'd0, e0});
        check_eq({tag, "_m1_ack"}, {31'd0, m1_ack}, {31'd0, e1});
    endtask

    logic        e0_t2 [6];
    logic        e1_t2 [6];
    logic [31:0] ea_t2 [6];
    logic        e0_t4 [8];
    logic        e1_t4 [8];

    initial begin
        e0_t2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        e1_t2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ea_t2 = '{32'h0, 32'h100, 32'h200, 32'h100, 32'h200, 32'h100};
        e0_t4 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e1_t4 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        clear_inputs();
        rst_n   = 1'b0;
        load_en = 1'b1; load_idx = 8'd4; load_val = 32'hDEADBEEF;   // 0x10
        next_cycle();
        load_idx = 8'd8; load_val = 32'hAAAABBBB;                   // 0x20
        next_cycle();
        load_en = 1'b0;

        // Reset state: everything quiet
        @(negedge clk);
        check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check_acks("rst", 1'b0, 1'b0);
        check_eq("rst_ram_addr", ram_addr, 32'd0);
        check_eq("rst_m0_rdata", m0_rdata, 32'd0);

        // 1: single M0 read of 0x10
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h10;
        @(negedge clk);
        check_acks("t1_c1", 1'b0, 1'b0);
        check_eq("t1_c1_ram_en", {31'd0, ram_en}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_acks("t1_c2", 1'b1, 1'b0);
        check_eq("t1_c2_ram_en", {31'd0, ram_en}, 32'd1);
        check_eq("t1_c2_rdata", m0_rdata, 32'hDEADBEEF);
        check_eq("t1_c2_ram_addr", ram_addr, 32'h10);
        next_cycle();
        m0_req = 1'b0;
        @(negedge clk);
        check_eq("t1_c3_ram_en", {31'd0, ram_en}, 32'd0);
        check_acks("t1_c3", 1'b0, 1'b0);
        check_eq("t1_c3_rdata", m0_rdata, 32'd0);

        // 2: both request for 6 cycles, no lock
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h200;
        for (int c = 0; c < 6; c++) begin
            if (c != 0) next_cycle();
            @(negedge clk);
            check_acks($sformatf("t2_c%0d", c + 1), e0_t2[c], e1_t2[c]);
            check_eq($sformatf("t2_c%0d_ram_addr", c + 1), ram_addr, ea_t2[c]);
        end
        next_cycle();
        clear_inputs();

        // 3: M1 partial write to 0x20, then M0 reads it back
        apply_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_sel = 4'b0011;
        @(negedge clk);
        check_eq("t3_c1_ram_we", {31'd0, ram_we}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_acks("t3_c2", 1'b0, 1'b1);
        check_eq("t3_c2_ram_we", {31'd0, ram_we}, 32'd1);
        check_eq("t3_c2_ram_sel", {28'd0, ram_sel}, 32'h3);
        check_eq("t3_c2_ram_wdata", ram_wdata, 32'h12345678);
        check_eq("t3_c2_ram_addr", ram_addr, 32'h20);
        next_cycle();
        clear_inputs();
        m0_req = 1'b1; m0_addr = 32'h20;
        @(negedge clk);
        check_eq("t3_c3_ram_we", {31'd0, ram_we}, 32'd0);
        check_eq("t3_c3_ram_en", {31'd0, ram_en}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_acks("t3_c4", 1'b1, 1'b0);
        check_eq("t3_c4_rdata", m0_rdata, 32'hAAAA5678);
        next_cycle();
        clear_inputs();

        // 4: M1 burst lock, MAX_HOLD = 4
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h200; m1_lock = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            @(negedge clk);
            check_acks($sformatf("t4_c%0d", c + 1), e0_t4[c], e1_t4[c]);
        end
        next_cycle();
        clear_inputs();

        // 5: reset while M1 is being served
        apply_reset();
        m1_req = 1'b1; m1_addr = 32'h30;
        @(negedge clk);
        check_acks("t5_c1", 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_acks("t5_c2", 1'b0, 1'b1);
        check_eq("t5_c2_ram_en", {31'd0, ram_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_async_ram_en", {31'd0, ram_en}, 32'd0);
        check_acks("t5_async", 1'b0, 1'b0);
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'h40;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_acks("t5_r1", 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_acks("t5_r2", 1'b1, 1'b0);
        check_eq("t5_r2_ram_addr", ram_addr, 32'h40);
        next_cycle();
        clear_inputs();

        // 6: M0 drops req in its grant cycle while M1 requests
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h10;
        @(negedge clk);
        check_acks("t6_c1", 1'b0, 1'b0);
        next_cycle();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h20;
        @(negedge clk);
        check_acks("t6_c2", 1'b0, 1'b0);
        check_eq("t6_c2_ram_en", {31'd0, ram_en}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_acks("t6_c3", 1'b0, 1'b1);
        check_eq("t6_c3_ram_en", {31'd0, ram_en}, 32'd1);
        check_eq("t6_c3_rdata", m1_rdata, 32'hAAAA5678);
        next_cycle();
        clear_inputs();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
